// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment display path:
// hex-to-segment decode, blank pattern and anode one-hot helper.
package seg7_pkg;

    // Segment pattern with every segment dark (active-high encoding).
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Widest anode vector the one-hot helper can produce.
    localparam int unsigned MAX_DIGITS = 32;

    // Hex digit to segments {g,f,e,d,c,b,a}, active-high, bit0 = a.
    function automatic logic [6:0] hex7(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // One-hot anode vector for a digit index; callers cast to their width.
    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [4:0] sel);
        logic [MAX_DIGITS-1:0] vec;
        vec = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to 7-segment decoder (active-high segments).
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for the current digit value.
    always_comb begin
        seg = hex7(hex);
    end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed NUM_DIGITS x 7-segment driver with per-digit blink,
// dead time between slots and a double-buffered digit frame.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 8,
    parameter int unsigned SCAN_DIV       = 1024,
    parameter int unsigned DEAD_CYCLES    = 4,
    parameter int unsigned BLINK_FRAMES   = 32,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1,
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    update,
    input  logic [NUM_DIGITS-1:0]   rotor_sel,
    input  logic                    blank_en,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IW-1:0]           digit_idx,
    output logic                    frame_tick
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]           scan_cnt;
    logic [IW-1:0]           idx;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_on;
    logic [4*NUM_DIGITS-1:0] pending;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    pend_vld;

    logic                    slot_end;
    logic                    fw;
    logic                    lit;
    logic [3:0]              cur_nibble;
    logic [6:0]              seg_next;

    logic [NUM_DIGITS-1:0]   an_r;
    logic [6:0]              seg_r;
    logic                    dp_r;

    // Slot and frame boundary detection plus the lit decision for this cycle.
    always_comb begin
        slot_end   = (scan_cnt == CW'(SCAN_DIV - 1));
        fw         = slot_end && (idx == IW'(NUM_DIGITS - 1));
        lit        = !blank_en
                     && (scan_cnt >= CW'(DEAD_CYCLES))
                     && !(rotor_sel[idx] && !blink_on);
        cur_nibble = shadow[{idx, 2'b00} +: 4];
    end

    hex_to_seg7 u_hex_to_seg7 (
        .hex (cur_nibble),
        .seg (seg_next)
    );

    // Slot counter and digit index; reset restarts the scan at slot 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (slot_end) begin
            scan_cnt <= '0;
            idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Blink phase advances once per completed frame.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (fw) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                blink_on  <= !blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Pending/shadow buffers: shadow only loads at the frame wrap, and an
    // update arriving on that same cycle bypasses the pending copy.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending  <= '0;
            shadow   <= '0;
            pend_vld <= 1'b0;
        end else if (fw) begin
            if (update) begin
                shadow   <= digits_in;
                pend_vld <= 1'b0;
            end else if (pend_vld) begin
                shadow   <= pending;
                pend_vld <= 1'b0;
            end
        end else if (update) begin
            pending  <= digits_in;
            pend_vld <= 1'b1;
        end
    end

    // Registered display outputs, one cycle behind the scan position.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            an_r       <= '0;
            seg_r      <= SEG_BLANK;
            dp_r       <= 1'b0;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            an_r       <= lit ? NUM_DIGITS'(onehot(5'(idx))) : '0;
            seg_r      <= seg_next;
            dp_r       <= lit && rotor_sel[idx];
            digit_idx  <= idx;
            frame_tick <= fw;
        end
    end

    assign an_out  = AN_ACTIVE_LOW  ? ~an_r  : an_r;
    assign seg_out = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
    assign dp_out  = SEG_ACTIVE_LOW ? ~dp_r  : dp_r;

endmodule
